// File: rtl/dual_issue_split.sv
// dual_issue_split: issue-pair sequencer for the dual-issue front end.
// Takes an (instr 1 @ PC, instr 2 @ PC+4) pair from fetch/decode. Independent
// pairs issue in both slots at once. A dependent pair issues instr 1 alone,
// then the held instr 2 alone in slot 1 on the next advancing cycle.
//
// Ports
//   ds_i_clk, ds_i_rst_n       clock, asynchronous active-low reset
//   ds_i_valid / ds_o_ready    pair handshake; ready is combinational
//   ds_i_instr_1/2, ds_i_pc    offered pair and PC of instr 1
//   ds_i_change_instr          pair is dependent and must split
//   ds_i_stall, ds_i_flush     freeze / discard (flush wins)
//   ds_o_valid/instr/pc_1/2    registered execute-lane slots
//   ds_o_split_cnt             saturating count of split pairs
module dual_issue_split #(
  parameter int IWIDTH = 32,
  parameter int PWIDTH = 32,
  parameter int CWIDTH = 16
) (
  input  logic              ds_i_clk,
  input  logic              ds_i_rst_n,
  input  logic              ds_i_valid,
  output logic              ds_o_ready,
  input  logic [IWIDTH-1:0] ds_i_instr_1,
  input  logic [IWIDTH-1:0] ds_i_instr_2,
  input  logic [PWIDTH-1:0] ds_i_pc,
  input  logic              ds_i_change_instr,
  input  logic              ds_i_stall,
  input  logic              ds_i_flush,
  output logic              ds_o_valid_1,
  output logic [IWIDTH-1:0] ds_o_instr_1,
  output logic [PWIDTH-1:0] ds_o_pc_1,
  output logic              ds_o_valid_2,
  output logic [IWIDTH-1:0] ds_o_instr_2,
  output logic [PWIDTH-1:0] ds_o_pc_2,
  output logic [CWIDTH-1:0] ds_o_split_cnt
);

  typedef enum logic {
    PAIR = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                valid_1_q, valid_1_d;
  logic [IWIDTH-1:0]   instr_1_q, instr_1_d;
  logic [PWIDTH-1:0]   pc_1_q, pc_1_d;
  logic                valid_2_q, valid_2_d;
  logic [IWIDTH-1:0]   instr_2_q, instr_2_d;
  logic [PWIDTH-1:0]   pc_2_q, pc_2_d;
  logic [IWIDTH-1:0]   hold_instr_q, hold_instr_d;
  logic [PWIDTH-1:0]   hold_pc_q, hold_pc_d;
  logic [CWIDTH-1:0]   split_cnt_q, split_cnt_d;

  logic                ready;
  logic                accept;
  logic [PWIDTH-1:0]   pc_plus4;

  // Wraps modulo 2^PWIDTH by construction.
  assign pc_plus4 = ds_i_pc + PWIDTH'(4);

  always_comb begin
    ready        = (state_q == PAIR) && !ds_i_stall && !ds_i_flush;
    accept       = ds_i_valid && ready;
    state_d      = state_q;
    valid_1_d    = valid_1_q;
    instr_1_d    = instr_1_q;
    pc_1_d       = pc_1_q;
    valid_2_d    = valid_2_q;
    instr_2_d    = instr_2_q;
    pc_2_d       = pc_2_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    split_cnt_d  = split_cnt_q;

    if (ds_i_flush) begin
      // Leaving HOLD drops the held instr 2; instr/pc payloads are don't-care.
      valid_1_d = 1'b0;
      valid_2_d = 1'b0;
      state_d   = PAIR;
    end else if (!ds_i_stall) begin
      unique case (state_q)
        PAIR: begin
          if (accept) begin
            valid_1_d = 1'b1;
            instr_1_d = ds_i_instr_1;
            pc_1_d    = ds_i_pc;
            if (ds_i_change_instr) begin
              valid_2_d    = 1'b0;
              hold_instr_d = ds_i_instr_2;
              hold_pc_d    = pc_plus4;
              state_d      = HOLD;
              if (split_cnt_q != '1) begin
                split_cnt_d = split_cnt_q + CWIDTH'(1);
              end
            end else begin
              valid_2_d = 1'b1;
              instr_2_d = ds_i_instr_2;
              pc_2_d    = pc_plus4;
            end
          end else begin
            valid_1_d = 1'b0;
            valid_2_d = 1'b0;
          end
        end
        HOLD: begin
          // Held instr 2 is now the oldest, so it goes out in slot 1.
          valid_1_d = 1'b1;
          instr_1_d = hold_instr_q;
          pc_1_d    = hold_pc_q;
          valid_2_d = 1'b0;
          state_d   = PAIR;
        end
        default: state_d = PAIR;
      endcase
    end
  end

  always_ff @(posedge ds_i_clk or negedge ds_i_rst_n) begin
    if (!ds_i_rst_n) begin
      state_q      <= PAIR;
      valid_1_q    <= 1'b0;
      instr_1_q    <= '0;
      pc_1_q       <= '0;
      valid_2_q    <= 1'b0;
      instr_2_q    <= '0;
      pc_2_q       <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      split_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      valid_1_q    <= valid_1_d;
      instr_1_q    <= instr_1_d;
      pc_1_q       <= pc_1_d;
      valid_2_q    <= valid_2_d;
      instr_2_q    <= instr_2_d;
      pc_2_q       <= pc_2_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      split_cnt_q  <= split_cnt_d;
    end
  end

  assign ds_o_ready     = ready;
  assign ds_o_valid_1   = valid_1_q;
  assign ds_o_instr_1   = instr_1_q;
  assign ds_o_pc_1      = pc_1_q;
  assign ds_o_valid_2   = valid_2_q;
  assign ds_o_instr_2   = instr_2_q;
  assign ds_o_pc_2      = pc_2_q;
  assign ds_o_split_cnt = split_cnt_q;

endmodule

// File: tb/tb_dual_issue_split.sv
// Directed testbench for dual_issue_split. A second instance with a 2-bit
// split counter shares all inputs so counter saturation can be observed.
module tb_dual_issue_split;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] i1, i2, pc;
  logic        change, stall, flush;

  logic        ready, v1, v2;
  logic [31:0] o_i1, o_i2, o_pc1, o_pc2;
  logic [15:0] cnt;

  logic        s_ready, s_v1, s_v2;
  logic [31:0] s_i1, s_i2, s_pc1, s_pc2;
  logic [1:0]  s_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam logic [31:0] A = 32'h012A4020;
  localparam logic [31:0] B = 32'h014B4822;

  dual_issue_split dut (
    .ds_i_clk(clk), .ds_i_rst_n(rst_n), .ds_i_valid(valid), .ds_o_ready(ready),
    .ds_i_instr_1(i1), .ds_i_instr_2(i2), .ds_i_pc(pc),
    .ds_i_change_instr(change), .ds_i_stall(stall), .ds_i_flush(flush),
    .ds_o_valid_1(v1), .ds_o_instr_1(o_i1), .ds_o_pc_1(o_pc1),
    .ds_o_valid_2(v2), .ds_o_instr_2(o_i2), .ds_o_pc_2(o_pc2),
    .ds_o_split_cnt(cnt)
  );

  dual_issue_split #(.IWIDTH(32), .PWIDTH(32), .CWIDTH(2)) dut_sat (
    .ds_i_clk(clk), .ds_i_rst_n(rst_n), .ds_i_valid(valid), .ds_o_ready(s_ready),
    .ds_i_instr_1(i1), .ds_i_instr_2(i2), .ds_i_pc(pc),
    .ds_i_change_instr(change), .ds_i_stall(stall), .ds_i_flush(flush),
    .ds_o_valid_1(s_v1), .ds_o_instr_1(s_i1), .ds_o_pc_1(s_pc1),
    .ds_o_valid_2(s_v2), .ds_o_instr_2(s_i2), .ds_o_pc_2(s_pc2),
    .ds_o_split_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic dep);
    valid = 1'b1; i1 = a; i2 = b; pc = p; change = dep;
  endtask

  task automatic idle();
    valid = 1'b0; change = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; i1 = '0; i2 = '0; pc = '0;
    change = 1'b0; stall = 1'b0; flush = 1'b0;

    // Reset state
    tick();
    check("rst_v1", v1, 0);
    check("rst_v2", v2, 0);
    check("rst_pc1", o_pc1, 0);
    check("rst_instr1", o_i1, 0);
    check("rst_cnt", cnt, 0);
    rst_n = 1'b1;
    #1;
    check("rst_ready", ready, 1);

    // Independent pair
    offer(A, B, 32'h100, 1'b0);
    tick();
    idle();
    #1;
    check("ind_v1", v1, 1);
    check("ind_i1", o_i1, A);
    check("ind_pc1", o_pc1, 32'h100);
    check("ind_v2", v2, 1);
    check("ind_i2", o_i2, B);
    check("ind_pc2", o_pc2, 32'h104);
    check("ind_ready", ready, 1);
    check("ind_cnt", cnt, 0);

    // Dependent pair
    offer(A, B, 32'h100, 1'b1);
    tick();
    idle();
    #1;
    check("dep1_v1", v1, 1);
    check("dep1_i1", o_i1, A);
    check("dep1_pc1", o_pc1, 32'h100);
    check("dep1_v2", v2, 0);
    check("dep1_ready", ready, 0);
    check("dep1_cnt", cnt, 1);
    tick();
    check("dep2_v1", v1, 1);
    check("dep2_i1", o_i1, B);
    check("dep2_pc1", o_pc1, 32'h104);
    check("dep2_v2", v2, 0);
    check("dep2_ready", ready, 1);
    tick();
    check("dep3_v1", v1, 0);

    // Stall in HOLD: the offered pair is ignored, slot 1 keeps instr 1
    offer(A, B, 32'h100, 1'b1);
    tick();
    offer(32'hDEAD0001, 32'hDEAD0002, 32'h500, 1'b0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stl_ready", ready, 0);
      tick();
      check("stl_v1", v1, 1);
      check("stl_i1", o_i1, A);
      check("stl_v2", v2, 0);
    end
    stall = 1'b0;
    idle();
    tick();
    check("stl_rel_i1", o_i1, B);
    check("stl_rel_pc1", o_pc1, 32'h104);
    check("stl_rel_v1", v1, 1);
    tick();
    check("stl_nodup_v1", v1, 0);
    check("stl_cnt", cnt, 2);

    // Flush in HOLD: held instr 2 dropped, offered pair not accepted
    offer(A, B, 32'h200, 1'b1);
    tick();
    offer(32'hCAFE0001, 32'hCAFE0002, 32'h600, 1'b0);
    flush = 1'b1;
    #1;
    check("fl_ready", ready, 0);
    tick();
    check("fl_v1", v1, 0);
    check("fl_v2", v2, 0);
    flush = 1'b0;
    idle();
    #1;
    check("fl_ready_after", ready, 1);
    tick();
    check("fl_never_v1", v1, 0);
    check("fl_cnt", cnt, 3);

    // Stall in PAIR holds outputs; flush+stall together clears them
    offer(A, B, 32'h400, 1'b0);
    tick();
    stall = 1'b1;
    offer(32'h11111111, 32'h22222222, 32'h800, 1'b0);
    tick();
    check("stp_v2", v2, 1);
    check("stp_pc1", o_pc1, 32'h400);
    flush = 1'b1;
    tick();
    check("fls_v1", v1, 0);
    check("fls_v2", v2, 0);
    flush = 1'b0; stall = 1'b0;

    // PC wrap
    offer(A, B, 32'hFFFFFFFC, 1'b0);
    tick();
    idle();
    check("wrap_pc1", o_pc1, 32'hFFFFFFFC);
    check("wrap_pc2", o_pc2, 32'h00000000);
    check("wrap_v2", v2, 1);

    // Async reset while in HOLD
    offer(A, B, 32'h300, 1'b1);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_v1", v1, 0);
    check("ar_v2", v2, 0);
    check("ar_pc1", o_pc1, 0);
    check("ar_pc2", o_pc2, 0);
    check("ar_cnt", cnt, 0);
    check("ar_cnt_sat", s_cnt, 0);
    rst_n = 1'b1;
    #1;
    check("ar_ready", ready, 1);
    tick();
    check("ar_lost_v1", v1, 0);

    // Five back-to-back dependent pairs
    offer(A, B, 32'h1000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sat_pair_i1", o_i1, A);
      tick();
      check("sat_held_i1", o_i1, B);
      if (k == 1) check("sat_cnt2", s_cnt, 2);
    end
    idle();
    check("sat_cnt_small", s_cnt, 3);
    check("sat_cnt_wide", cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dual_issue_split.md
# dual_issue_split

Issue-pair sequencer for the dual-issue front end. Accepts an instruction pair (instr 1 at PC, instr 2 at PC+4) from the fetch/decode boundary, together with the dependency flag produced by the rd-vs-rs/rt duplicate checker. An independent pair is issued in both slots together. A dependent pair is split: instr 1 issues alone, and instr 2 is held and issued alone on the next advancing cycle. Outputs are registered and feed the two execute lanes.

## Interface
- IWIDTH, 32, instruction width
- PWIDTH, 32, PC width
- CWIDTH, 16, split-event counter width
- ds_i_clk  in  1  clock; all state updates on the rising edge
- ds_i_rst_n  in  1  asynchronous, active-low reset
- ds_i_valid  in  1  fetch offers a pair
- ds_o_ready  out  1  block accepts the pair this cycle (combinational)
- ds_i_instr_1  in  IWIDTH  older instruction
- ds_i_instr_2  in  IWIDTH  younger instruction
- ds_i_pc  in  PWIDTH  PC of instr 1
- ds_i_change_instr  in  1  1 = instr 2 reads the rd of instr 1, so the pair must split
- ds_i_stall  in  1  downstream stall; freezes the block
- ds_i_flush  in  1  discard all held and issued work
- ds_o_valid_1, ds_o_instr_1, ds_o_pc_1  out  1/IWIDTH/PWIDTH  slot 1
- ds_o_valid_2, ds_o_instr_2, ds_o_pc_2  out  1/IWIDTH/PWIDTH  slot 2
- ds_o_split_cnt  out  CWIDTH  saturating count of split pairs

## Operation
- **States:** PAIR (accepting) and HOLD (a held instr 2 is pending).
- **Ready:** ds_o_ready = (state==PAIR) & !ds_i_stall & !ds_i_flush.
- **Accept:** an accept occurs when ds_i_valid & ds_o_ready.
- **Priority per edge:** flush > stall > normal.
- **Flush:** both valids go to 0, the hold register valid goes to 0, state goes to PAIR. Instr/PC output values are don't-care. The counter is unchanged.
- **Stall (no flush):** all registers, state and counter hold their values.
- **PAIR with accept and change_instr=0:**
  - slot 1 = {1, instr_1, pc}
  - slot 2 = {1, instr_2, pc+4}
  - state stays PAIR.
- **PAIR with accept and change_instr=1:**
  - slot 1 = {1, instr_1, pc}, and ds_o_valid_2 = 0
  - hold register = {instr_2, pc+4}
  - state goes to HOLD
  - counter increments, saturating at all-ones.
- **PAIR, no accept:** both valids go to 0.
- **HOLD (not stalled, not flushed):**
  - slot 1 = {1, held instr, held pc}, and ds_o_valid_2 = 0
  - state goes to PAIR
  - ds_o_ready is 0 throughout HOLD.
- **PC arithmetic:** pc+4 is computed modulo 2^PWIDTH, so 0xFFFFFFFC yields 0x00000000.
- **Don't-care flag:** ds_i_change_instr is ignored on any cycle without an accept.
- **Program order:** a split instr 2 always emerges in slot 1, never slot 2. Slot 1 is always the oldest valid instruction.

## Timing
- **Reset values:** state=PAIR; ds_o_valid_1=ds_o_valid_2=0; ds_o_instr_*=0; ds_o_pc_*=0; hold register=0; ds_o_split_cnt=0. Consequently ds_o_ready=1 after reset unless stall or flush is asserted.
- **Latency:** an accepted pair appears on the outputs one cycle after the accepting edge.
- **Throughput:**
  - independent pairs: 2 instructions per cycle
  - dependent pairs: 2 instructions per 2 cycles, with ready low for exactly 1 unstalled cycle.
- **Stall during HOLD:** HOLD persists, and instr 2 issues on the first unstalled edge.
- **Flush during HOLD:** the held instr 2 is dropped and never issued. The pair offered in that cycle is not accepted.
- **Flush and stall together:** flush wins.
- **Reset mid-HOLD:** the held instruction is lost, and all outputs return to their reset values immediately, since reset is asynchronous.
- **Output stability:** outputs are pure register outputs. Only ds_o_ready is combinational.

## Test plan
- **Independent pair:** instr_1=0x012A4020, instr_2=0x014B4822, pc=0x100, change=0 -> next cycle both valids=1, pc_1=0x100, pc_2=0x104, ready stays 1, split_cnt=0.
- **Dependent pair:** same pair with change=0 -> change=1 -> cycle+1: slot 1 = instr_1 at pc 0x100, valid_2=0, ready=0. Cycle+2: slot 1 = instr_2 at pc 0x104, valid_2=0, ready=1. split_cnt=1.
- **Stall in HOLD:** dependent pair, then stall=1 for 3 cycles -> slot 1 keeps instr_1 and ready=0 for 3 cycles. After stall drops, instr_2 at 0x104 issues once, with no duplicate.
- **Flush in HOLD:** dependent pair, then flush=1 for one cycle -> both valids=0 on the next cycle, instr_2 is never issued, ready=1 after flush drops.
- **PC wrap and saturation:** pc=0xFFFFFFFC with change=0 -> pc_2=0x00000000. With CWIDTH=2, 5 consecutive dependent pairs -> split_cnt stops at 3.
- **Async reset mid-operation:** drop ds_i_rst_n between edges while in HOLD -> valids, pcs and split_cnt read 0 immediately, and ready=1 once reset is released.
